// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Bits needed to index n requesters (never less than 1).
  function automatic int unsigned clog2_id(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer streams plus FIFO write port and grant status, as seen by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned BCNT_WIDTH = 8
);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ*DATA_WIDTH-1:0]  req_data;
  logic [N_REQ-1:0]             req_ready;
  logic                         fifo_full;
  logic                         fifo_wr_en;
  logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_wr_data;
  logic                         grant_valid;
  logic [ID_WIDTH-1:0]          grant_id;
  logic [BCNT_WIDTH-1:0]        beat_cnt;

  // Producers and FIFO status side.
  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, beat_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, beat_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, with wrap.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  localparam int unsigned SW = IW + 1;
  localparam int unsigned AW = IW + 2;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [SW-1:0]  w_start;
  logic [SW-1:0]  w_pos;
  logic [AW-1:0]  w_sum;
  logic [AW-1:0]  w_wrap;

  assign o_any   = |i_req;
  assign w_dbl   = {i_req, i_req};
  assign w_start = SW'(i_last) + SW'(1);

  // Rotating the doubled vector puts requester (last+1) at bit 0.
  assign w_rot = N'(w_dbl >> w_start);

  always_comb begin
    w_pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_pos = SW'(i);
      end
    end
  end

  assign w_sum  = AW'(w_start) + AW'(w_pos);
  assign w_wrap = (w_sum >= AW'(N)) ? (w_sum - AW'(N)) : w_sum;
  assign o_idx  = IW'(w_wrap);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one sync FIFO write port among N_REQ
// valid/ready producers; beats are tagged with the owner ID.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned BCNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned FIFO_W = DATA_WIDTH + ID_WIDTH;

  if (N_REQ < 2 || N_REQ > 16) begin : g_chk_nreq
    $error("fifo_wr_arbiter: N_REQ must be within 2..16");
  end
  if (ID_WIDTH != clog2_id(N_REQ)) begin : g_chk_id
    $error("fifo_wr_arbiter: ID_WIDTH must equal clog2(N_REQ)");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_burst
    $error("fifo_wr_arbiter: MAX_BURST must be within 1..255");
  end
  if ((MAX_BURST >> BCNT_WIDTH) != 0) begin : g_chk_bcnt
    $error("fifo_wr_arbiter: BCNT_WIDTH too narrow for MAX_BURST");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [ID_WIDTH-1:0]   w_grant_id_nxt;
  logic [ID_WIDTH-1:0]   r_last;
  logic [ID_WIDTH-1:0]   w_last_nxt;
  logic [BCNT_WIDTH-1:0] r_beat_cnt;
  logic [BCNT_WIDTH-1:0] w_bcnt_nxt;
  logic                  r_grant_valid;

  logic                  w_any;
  logic [ID_WIDTH-1:0]   w_pick;
  logic [N_REQ-1:0]      w_ready;
  logic                  w_xfer;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic                  w_burst_end;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic [DATA_WIDTH-1:0] w_payload [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_payload
    assign w_payload[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_pick)
  );

  assign w_owner_valid = bus.req_valid[r_grant_id];
  assign w_owner_last  = bus.req_last[r_grant_id];
  assign w_owner_data  = w_payload[r_grant_id];
  assign w_burst_end   = (r_beat_cnt == BCNT_WIDTH'(MAX_BURST - 1));

  // Next-state, counters and combinational handshake; rst blocks any write in its cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    w_last_nxt     = r_last;
    w_bcnt_nxt     = r_beat_cnt;
    w_ready        = '0;
    w_xfer         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_id_nxt = w_pick;
          w_last_nxt     = w_pick;
          w_bcnt_nxt     = '0;
          w_state_nxt    = GRANT;
        end
      end
      GRANT: begin
        w_ready[r_grant_id] = !bus.fifo_full && !rst;
        w_xfer              = w_owner_valid && !bus.fifo_full && !rst;
        if (w_xfer) begin
          w_bcnt_nxt = r_beat_cnt + BCNT_WIDTH'(1);
        end
        if (!w_owner_valid || (w_xfer && (w_owner_last || w_burst_end))) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant_id    <= '0;
      r_last        <= ID_WIDTH'(N_REQ - 1);
      r_beat_cnt    <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_last        <= w_last_nxt;
      r_beat_cnt    <= w_bcnt_nxt;
      r_grant_valid <= (w_state_nxt == GRANT);
    end
  end

  logic [FIFO_W-1:0] w_wr_data;
  assign w_wr_data = {r_grant_id, w_owner_data};

  assign bus.req_ready    = w_ready;
  assign bus.fifo_wr_en   = w_xfer;
  assign bus.fifo_wr_data = w_wr_data;
  assign bus.grant_valid  = r_grant_valid;
  assign bus.grant_id     = r_grant_id;
  assign bus.beat_cnt     = r_beat_cnt;

  // Run-time invariants of the write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_xfer && bus.fifo_full))
        else $error("fifo_wr_arbiter: write while fifo_full");
      assert (r_beat_cnt <= BCNT_WIDTH'(MAX_BURST))
        else $error("fifo_wr_arbiter: burst exceeded MAX_BURST");
      assert (r_grant_valid == (r_state == GRANT))
        else $error("fifo_wr_arbiter: grant_valid out of step with state");
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares one sync FIFO write port among N_REQ producers, using a round-robin arbiter with burst and packet awareness.
Each producer presents a valid/ready stream with an end-of-packet marker. The arbiter grants one producer at a time and forwards its beats to the FIFO write port, tagged with the producer ID.
Sits directly in front of the FIFO. The FIFO data width is DATA_WIDTH+ID_WIDTH, and the FIFO fifo_full output feeds back into this block.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, payload width per requester
ID_WIDTH, 2, requester ID width; must equal clog2(N_REQ)
MAX_BURST, 4, maximum beats per grant (1..255)
BCNT_WIDTH, 8, beat counter width; must hold MAX_BURST

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
req_valid  in  N_REQ  per-requester beat valid
req_last  in  N_REQ  per-requester end-of-packet, qualified by valid
req_data  in  N_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  N_REQ  per-requester accept (combinational)
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable (combinational)
fifo_wr_data  out  DATA_WIDTH+ID_WIDTH  {grant_id, owner payload}
grant_valid  out  1  a requester currently owns the port
grant_id  out  ID_WIDTH  current or last owner
beat_cnt  out  BCNT_WIDTH  beats accepted in the current grant

Behaviour:
- Reset state: IDLE, grant_valid=0, grant_id=0, beat_cnt=0, req_ready=0, fifo_wr_en=0.
  - The round-robin pointer resets to last=N_REQ-1, so requester 0 has first priority.
- rst has priority over everything. Reset mid-burst aborts the grant on the next edge; a beat presented in the reset cycle is not written.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from (last+1) mod N_REQ upward with wrap.
  - Register grant_id, set last=grant_id, clear beat_cnt, go to GRANT.
  - Arbitration latency is 1 cycle: valid seen at edge k, first beat possible in cycle k+1.
  - No valid: stay in IDLE.
- GRANT:
  - req_ready[grant_id] = !fifo_full; all other ready bits = 0.
  - Transfer = req_valid[grant_id] && req_ready[grant_id].
  - fifo_wr_en = transfer.
  - fifo_wr_data = {grant_id, req_data[grant_id]}; its value is don't-care when fifo_wr_en=0.
  - Each transfer increments beat_cnt.
- Release to IDLE at the edge where any of these holds:
  - (a) transfer && req_last[grant_id]
  - (b) transfer && beat_cnt==MAX_BURST-1
  - (c) req_valid[grant_id]==0
- One bubble cycle in IDLE follows every release; peak throughput with continuous contention is MAX_BURST/(MAX_BURST+1).
- fifo_full stalls the grant:
  - ready, wr_en and beat_cnt are frozen.
  - The grant is held indefinitely while the owner keeps valid high.
  - No write may occur while fifo_full=1.
- MAX_BURST may cut a packet. Downstream reassembles by ID tag; packet atomicity is not guaranteed.
- Producers must hold data/last stable while valid && !ready (standard valid/ready rules). The arbiter does not check this.
- grant_id holds its value in IDLE. grant_valid=1 exactly when state is GRANT.
- MAX_BURST=1 degenerates to per-beat round-robin with a bubble between beats.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - the ID_WIDTH-from-N_REQ clog2 helper function
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last pointer.
  - Outputs: any-request flag, chosen index.
  - Implemented with a doubled-vector mask; reusable for a future read-side scheduler.
- Top level holds the FSM, beat counter, output muxing and parameter-consistency assertions.

Test Plan:
- Single requester 1, valid continuous, last on beat 3, payloads 0xA1/0xA2/0xA3, fifo_full=0:
  - cycle 0 IDLE
  - wr_en in cycles 1–3 with data {1,A1},{1,A2},{1,A3}
  - grant_valid drops in cycle 4
- All four requesters valid continuously, no last, MAX_BURST=4:
  - grant order 0,1,2,3,0
  - 4 beats each, 1 idle cycle between grants
  - 16 writes in 20 cycles
- Requester 0 in GRANT, fifo_full=1 for 3 cycles after beat 2:
  - ready=0 and wr_en=0 for those 3 cycles, beat_cnt stays 2
  - beats 3–4 written afterwards, then release
- Requester 2 drops valid after 2 beats while 1 and 3 are waiting:
  - release at that edge
  - next grant goes to 3 (rr from 2), then to 1
- rst asserted in cycle 2 of a grant to requester 1:
  - beat in the rst cycle is not written
  - next cycle IDLE, grant_valid=0
  - with 1 and 0 both valid, the next grant goes to 0
- Random valid/last/full stimulus for 10k cycles:
  - scoreboard per ID matches FIFO contents in order
  - no write while fifo_full=1
  - no grant exceeds MAX_BURST beats
